// File: rtl/morse_decoder_if.sv
// morse_decoder_if: serial line and decoded-letter bundle for morse_decoder.
//   DotDashIn   : serial Morse line (1 = tone), driven by the line side
//   LetterOut   : last successfully decoded letter code (000=A .. 111=H)
//   LetterValid : one-cycle pulse, LetterOut just updated
//   LetterError : one-cycle pulse, 12 bits received but no table match
//   Busy        : a character is being received or decoded
// master = line source / letter consumer, slave = the decoder.
interface morse_decoder_if;
    logic       DotDashIn;
    logic [2:0] LetterOut;
    logic       LetterValid;
    logic       LetterError;
    logic       Busy;

    modport master (
        output DotDashIn,
        input  LetterOut, LetterValid, LetterError, Busy
    );

    modport slave (
        input  DotDashIn,
        output LetterOut, LetterValid, LetterError, Busy
    );
endinterface

// File: rtl/morse_decoder.sv
// morse_decoder: receive side of the lab Morse link. Samples a dot/dash line
// at one bit per CLOCK_FREQUENCY/2 cycles, rebuilds the 12-bit pattern and
// maps it back to the 3-bit letter code for A..H.
//   ClockIn : system clock, rising edge
//   ResetN  : synchronous active-low reset
//   bus     : morse_decoder_if.slave (DotDashIn in; LetterOut, LetterValid,
//             LetterError, Busy out, all registered)
// Optional build macro MORSE_DECODER_SYNC_EN: when defined, DotDashIn goes
// through a 2-flop synchronizer first (all latencies +2 cycles); when
// undefined the line must already be synchronous to ClockIn.
module morse_decoder #(
    parameter int CLOCK_FREQUENCY = 500
) (
    input  logic            ClockIn,
    input  logic            ResetN,
    morse_decoder_if.slave  bus
);

    localparam int P  = CLOCK_FREQUENCY / 2;
    localparam int H  = P / 2;
    localparam int DW = (P > 1) ? $clog2(P) : 1;

    // First sample lands mid-bit (H cycles after the start edge), then every P.
    localparam logic [DW-1:0] DIV_START  = DW'(H - 1);
    localparam logic [DW-1:0] DIV_RELOAD = DW'(P - 1);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t        state;
    logic [DW-1:0] divider;
    logic [3:0]    bit_cnt;
    logic [11:0]   shift;
    logic          prev_line;
    logic          line;
    logic [3:0]    dec;     // {hit, code}

`ifdef MORSE_DECODER_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge ClockIn) begin
        if (!ResetN) sync <= 2'b00;
        else         sync <= {sync[0], bus.DotDashIn};
    end
    assign line = sync[1];
`else
    assign line = bus.DotDashIn;
`endif

    function automatic logic [3:0] decode(input logic [11:0] p);
        case (p)
            12'b101110000000: decode = 4'b1_000;  // A
            12'b111010101000: decode = 4'b1_001;  // B
            12'b111010111010: decode = 4'b1_010;  // C
            12'b111010100000: decode = 4'b1_011;  // D
            12'b100000000000: decode = 4'b1_100;  // E
            12'b101011101000: decode = 4'b1_101;  // F
            12'b111011101000: decode = 4'b1_110;  // G
            12'b101010100000: decode = 4'b1_111;  // H
            default:          decode = 4'b0_000;
        endcase
    endfunction

    assign dec = decode(shift);

    always_ff @(posedge ClockIn) begin
        if (!ResetN) begin
            state           <= IDLE;
            divider         <= '0;
            bit_cnt         <= '0;
            shift           <= '0;
            // Starts high so a line already high at reset release is no start.
            prev_line       <= 1'b1;
            bus.LetterOut   <= 3'b000;
            bus.LetterValid <= 1'b0;
            bus.LetterError <= 1'b0;
            bus.Busy        <= 1'b0;
        end else begin
            prev_line       <= line;
            bus.LetterValid <= 1'b0;
            bus.LetterError <= 1'b0;
            case (state)
                IDLE: begin
                    if (line && !prev_line) begin
                        divider  <= DIV_START;
                        bit_cnt  <= '0;
                        state    <= RECV;
                        bus.Busy <= 1'b1;
                    end
                end
                RECV: begin
                    if (divider == '0) begin
                        if (bit_cnt == 4'd0 && !line) begin
                            // Start edge was a glitch: line low mid first bit.
                            state    <= IDLE;
                            bus.Busy <= 1'b0;
                        end else begin
                            shift   <= {shift[10:0], line};
                            divider <= DIV_RELOAD;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd11) state <= DONE;
                        end
                    end else begin
                        divider <= divider - DW'(1);
                    end
                end
                DONE: begin
                    if (dec[3]) begin
                        bus.LetterOut   <= dec[2:0];
                        bus.LetterValid <= 1'b1;
                    end else begin
                        bus.LetterError <= 1'b1;
                    end
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: directed + randomized bench for morse_decoder at
// CLOCK_FREQUENCY=8 (P=4, H=2). Expected letters come from a pattern table
// lookup; expected timing from the bit-period arithmetic.
module tb_morse_decoder;

    localparam int CF = 8;
    localparam int P  = CF / 2;

    logic ClockIn = 1'b0;
    logic ResetN  = 1'b0;
    always #5 ClockIn = ~ClockIn;

    morse_decoder_if bus();

    morse_decoder #(.CLOCK_FREQUENCY(CF)) dut (
        .ClockIn (ClockIn),
        .ResetN  (ResetN),
        .bus     (bus.slave)
    );

    int         compared   = 0;
    int         mismatched = 0;
    logic [2:0] exp_out    = 3'b000;

    logic [11:0] pat_tab [8] = '{
        12'b101110000000, 12'b111010101000, 12'b111010111010, 12'b111010100000,
        12'b100000000000, 12'b101011101000, 12'b111011101000, 12'b101010100000
    };

    function automatic int lookup(input logic [11:0] p);
        for (int i = 0; i < 8; i++)
            if (pat_tab[i] == p) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ClockIn);
        #1;
    endtask

    // Line idle low for n cycles: decoder must stay quiet.
    task automatic idle(input int n);
        bus.DotDashIn = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_busy", 32'(bus.Busy), 0);
            check("idle_valid", 32'(bus.LetterValid), 0);
            check("idle_error", 32'(bus.LetterError), 0);
        end
    endtask

    // Drive a 12-bit pattern, P cycles per bit, first bit seen at edge 0.
    // Returns just after edge 12P-1, the edge that publishes the result.
    task automatic send(input logic [11:0] pat);
        int idx;
        int e;
        idx = lookup(pat);
        check("pre_busy", 32'(bus.Busy), 0);
        for (int k = 0; k < 12; k++) begin
            bus.DotDashIn = pat[11-k];
            for (int c = 0; c < P; c++) begin
                tick();
                e = k * P + c;
                if (e < 12 * P - 1) begin
                    check("rx_busy", 32'(bus.Busy), 1);
                    check("rx_valid", 32'(bus.LetterValid), 0);
                    check("rx_error", 32'(bus.LetterError), 0);
                end
            end
        end
        if (idx >= 0) exp_out = 3'(idx);
        check("done_busy", 32'(bus.Busy), 0);
        check("done_valid", 32'(bus.LetterValid), (idx >= 0) ? 1 : 0);
        check("done_error", 32'(bus.LetterError), (idx < 0) ? 1 : 0);
        check("done_letter", 32'(bus.LetterOut), 32'(exp_out));
    endtask

    initial begin
        logic [11:0] pat;
        bus.DotDashIn = 1'b0;

        // Reset state
        ResetN = 1'b0;
        tick(); tick();
        check("rst_letter", 32'(bus.LetterOut), 0);
        check("rst_valid", 32'(bus.LetterValid), 0);
        check("rst_error", 32'(bus.LetterError), 0);
        check("rst_busy", 32'(bus.Busy), 0);
        ResetN = 1'b1;
        idle(2);

        // C, then E and H back to back
        send(12'b111010111010);
        idle(1);
        send(12'b100000000000);
        send(12'b101010100000);
        idle(1);

        // Unknown pattern: error pulse, letter holds H
        send(12'b111111111110);
        idle(1);

        // One-cycle glitch: false start rejected at first sample (edge H)
        bus.DotDashIn = 1'b1;
        tick();
        check("glitch_busy0", 32'(bus.Busy), 1);
        bus.DotDashIn = 1'b0;
        tick();
        check("glitch_busy1", 32'(bus.Busy), 1);
        tick();
        check("glitch_busy2", 32'(bus.Busy), 0);
        check("glitch_valid", 32'(bus.LetterValid), 0);
        check("glitch_error", 32'(bus.LetterError), 0);
        idle(3);

        // Reset in the middle of G aborts it; then A decodes to 000
        pat = pat_tab[6];
        for (int k = 0; k < 6; k++) begin
            bus.DotDashIn = pat[11-k];
            repeat (P) tick();
        end
        bus.DotDashIn = pat[5];
        tick();
        ResetN = 1'b0;
        bus.DotDashIn = 1'b0;
        tick();
        exp_out = 3'b000;
        check("midrst_busy", 32'(bus.Busy), 0);
        check("midrst_letter", 32'(bus.LetterOut), 0);
        check("midrst_valid", 32'(bus.LetterValid), 0);
        ResetN = 1'b1;
        idle(2);
        send(pat_tab[0]);
        idle(1);

        // Line already high when reset releases: not a start
        ResetN = 1'b0;
        bus.DotDashIn = 1'b1;
        tick();
        ResetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("highrel_busy", 32'(bus.Busy), 0);
        end
        idle(2);

        // Randomized letters and junk patterns with random idle gaps
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) != 0) pat = pat_tab[$urandom_range(0, 7)];
            else                           pat = {1'b1, 10'($urandom), 1'b0};
            send(pat);
            idle(int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
